// File: rtl/gate_stim_checker.sv
// gate_stim_checker: drives the four {a,b} input vectors of a 2-input gate,
// waits SETTLE_CYCLES after each vector, checks y against a&b, and repeats
// the table REPEAT times. It reports a mismatch count and a pass/fail result.
// Optional macro GATE_CHK_FIRST_FAIL_EN captures the index of the first
// failing vector of each run.
module gate_stim_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Last value of each counter before it wraps or exits.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [3:0] REP_LAST    = 4'(REPEAT - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] rep_q, rep_d;
  logic [3:0] set_q, set_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic       mismatch;

  // The mismatch counter holds at its maximum value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign mismatch = (y != (a_q & b_q));

  // Next-state logic, counters and the result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    set_d   = set_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = 2'd0;
          rep_d   = 4'd0;
          err_d   = 8'd0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        set_d   = 4'd0;
        state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        if (set_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          set_d = set_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_DRIVE;
        end else if (rep_q != REP_LAST) begin
          idx_d   = 2'd0;
          rep_d   = rep_q + 4'd1;
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
          // Uses the count including this final check, so pass is valid with done.
          pass_d  = (err_d == 8'd0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Operands change only when a vector is first driven.
    if (state_d == S_DRIVE) begin
      a_d = idx_d[1];
      b_d = idx_d[0];
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      rep_q   <= 4'd0;
      set_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      set_q   <= set_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ffi_q, ffi_d;

  // Latch the first failing vector of a run; later mismatches leave it alone.
  always_comb begin
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    if ((state_q == S_IDLE) && start) begin
      ffv_d = 1'b0;
      ffi_d = 2'd0;
    end else if ((state_q == S_CHECK) && mismatch && !ffv_q) begin
      ffv_d = 1'b1;
      ffi_d = idx_q;
    end
  end

  // First-fail capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q <= 1'b0;
      ffi_q <= 2'd0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
    end
  end

  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
`else
  assign first_fail_vld = 1'b0;
  assign first_fail_idx = 2'b00;
`endif

endmodule
